// File: rtl/sxrRISC621_cache_pkg.sv
// Shared types and constants for the sxrRISC621 cache controller:
// field widths, address-field positions, FSM state encoding, and a
// priority-encoder helper.
package sxrRISC621_cache_pkg;

   localparam int TAG_W   = 8;
   localparam int OFF_W   = 2;
   localparam int DATA_W  = 14;
   localparam int ADDR_W  = TAG_W + OFF_W;
   localparam int WAYS    = 4;
   localparam int WAY_W   = 2;
   localparam int IDX_W   = WAY_W + OFF_W;
   localparam int WORDS   = WAYS * (1 << OFF_W);

   // Word address layout: tag in the upper bits, word offset in the lower bits
   localparam int TAG_MSB = ADDR_W - 1;
   localparam int TAG_LSB = OFF_W;
   localparam int OFF_MSB = OFF_W - 1;
   localparam int OFF_LSB = 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      FILL   = 3'd2,
      TAGWR  = 3'd3,
      WRMEM  = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Index of the lowest set bit; returns 0 when no bit is set
   function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] vec);
      lowest_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (vec[i]) lowest_way = WAY_W'(i);
      end
   endfunction

endpackage

// File: rtl/sxrRISC621_cache_data.sv
// Cache data store: 16 words indexed {way, offset}. Writes land on the
// rising edge; reads are combinational so a hit can be returned from the
// lookup cycle.
module sxrRISC621_cache_data
   import sxrRISC621_cache_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_arr [WORDS];

   // Synchronous write port
   always_ff @(posedge clk) begin
      if (we) mem_arr[waddr] <= wdata;
   end

   assign rdata = mem_arr[raddr];

endmodule

// File: rtl/sxrrisc621_cache_ctrl.sv
// Controller for the 4-way fully associative sxrRISC621 cache. Drives an
// external tag CAM, fills 4-word blocks on read misses over a req/ack
// memory port, and writes through to memory without allocating.
module sxrrisc621_cache_ctrl
   import sxrRISC621_cache_pkg::*;
(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cam_we_n,
   output logic [WAY_W-1:0]  cam_addrs,
   output logic [TAG_W-1:0]  cam_din,
   output logic [TAG_W-1:0]  cam_argin,
   input  logic [WAYS-1:0]   cam_mbits
);

   state_t             state_reg, state_next;
   logic [TAG_W-1:0]   tag_reg;
   logic [OFF_W-1:0]   off_reg;
   logic               we_reg;
   logic [DATA_W-1:0]  wdata_reg;
   logic [WAYS-1:0]    valid_reg;
   logic [WAY_W-1:0]   rr_reg;
   logic [OFF_W-1:0]   cnt_reg;
   logic [WAY_W-1:0]   victim_reg;
   logic               victim_rr_reg;
   logic [DATA_W-1:0]  rdata_reg;

   logic [WAYS-1:0]    hitvec;
   logic               hit;
   logic [WAY_W-1:0]   hit_way;
   logic               any_inv;
   logic [WAY_W-1:0]   inv_way;

   logic               dat_we;
   logic [IDX_W-1:0]   dat_waddr;
   logic [DATA_W-1:0]  dat_wdata;
   logic [DATA_W-1:0]  dat_rdata;

   // Unwritten CAM entries may report garbage, so only valid ways may hit
   assign hitvec    = cam_mbits & valid_reg;
   assign hit       = |hitvec;
   assign hit_way   = lowest_way(hitvec);
   assign any_inv   = ~&valid_reg;
   assign inv_way   = lowest_way(~valid_reg);

   assign cam_argin = tag_reg;
   assign cpu_rdata = rdata_reg;

   sxrRISC621_cache_data u_data (
      .clk   (Clock),
      .we    (dat_we),
      .waddr (dat_waddr),
      .wdata (dat_wdata),
      .raddr ({hit_way, off_reg}),
      .rdata (dat_rdata)
   );

   // State register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   // Next-state logic and all handshake/CAM/data-array strobes
   always_comb begin
      state_next = state_reg;
      cpu_ready  = 1'b0;
      cpu_done   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      cam_we_n   = 1'b1;
      cam_addrs  = '0;
      cam_din    = '0;
      dat_we     = 1'b0;
      dat_waddr  = '0;
      dat_wdata  = '0;
      case (state_reg)
         IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) state_next = LOOKUP;
         end
         LOOKUP: begin
            if (we_reg) begin
               state_next = WRMEM;
               if (hit) begin
                  dat_we    = 1'b1;
                  dat_waddr = {hit_way, off_reg};
                  dat_wdata = wdata_reg;
               end
            end else if (hit) begin
               state_next = DONE;
            end else begin
               state_next = FILL;
            end
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag_reg, cnt_reg};
            if (mem_ack) begin
               dat_we    = 1'b1;
               dat_waddr = {victim_reg, cnt_reg};
               dat_wdata = mem_rdata;
               if (&cnt_reg) state_next = TAGWR;
            end
         end
         TAGWR: begin
            cam_we_n   = 1'b0;
            cam_addrs  = victim_reg;
            cam_din    = tag_reg;
            state_next = DONE;
         end
         WRMEM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_reg, off_reg};
            mem_wdata = wdata_reg;
            if (mem_ack) state_next = DONE;
         end
         DONE: begin
            cpu_done   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture the request fields when a request is accepted in IDLE
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         tag_reg   <= '0;
         off_reg   <= '0;
         we_reg    <= 1'b0;
         wdata_reg <= '0;
      end else if (state_reg == IDLE && cpu_req) begin
         tag_reg   <= cpu_addr[TAG_MSB:TAG_LSB];
         off_reg   <= cpu_addr[OFF_MSB:OFF_LSB];
         we_reg    <= cpu_we;
         wdata_reg <= cpu_wdata;
      end
   end

   // Choose the fill victim on a read miss: first free way, else round-robin
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         victim_reg    <= '0;
         victim_rr_reg <= 1'b0;
      end else if (state_reg == LOOKUP && !we_reg && !hit) begin
         victim_reg    <= any_inv ? inv_way : rr_reg;
         victim_rr_reg <= !any_inv;
      end
   end

   // Fill word counter; wraps back to 0 after the last word of the block
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)                         cnt_reg <= '0;
      else if (state_reg == FILL && mem_ack) cnt_reg <= cnt_reg + 1'b1;
   end

   // Mark the filled way valid and advance round-robin only when it was used
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         valid_reg <= '0;
         rr_reg    <= '0;
      end else if (state_reg == TAGWR) begin
         valid_reg[victim_reg] <= 1'b1;
         if (victim_rr_reg) rr_reg <= rr_reg + 1'b1;
      end
   end

   // Read data: from the array on a hit, or the requested word as it streams in
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         rdata_reg <= '0;
      end else if (state_reg == LOOKUP && !we_reg && hit) begin
         rdata_reg <= dat_rdata;
      end else if (state_reg == FILL && mem_ack && cnt_reg == off_reg) begin
         rdata_reg <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_sxrrisc621_cache_ctrl.sv
// Self-checking bench for sxrrisc621_cache_ctrl with a behavioural tag
// CAM and a main-memory responder with programmable wait states.
module tb_sxrrisc621_cache_ctrl;

   logic        clk = 1'b0;
   logic        Resetn;
   logic        cpu_req, cpu_we;
   logic [9:0]  cpu_addr;
   logic [13:0] cpu_wdata;
   logic        cpu_ready, cpu_done;
   logic [13:0] cpu_rdata;
   logic        mem_req, mem_we;
   logic [9:0]  mem_addr;
   logic [13:0] mem_wdata;
   logic        mem_ack;
   logic [13:0] mem_rdata;
   logic        cam_we_n;
   logic [1:0]  cam_addrs;
   logic [7:0]  cam_din, cam_argin;
   logic [3:0]  cam_mbits;

   sxrrisc621_cache_ctrl dut (
      .Clock(clk), .Resetn(Resetn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .cam_we_n(cam_we_n), .cam_addrs(cam_addrs), .cam_din(cam_din),
      .cam_argin(cam_argin), .cam_mbits(cam_mbits)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Tag CAM: not reset; every entry starts as tag 0x05 so stale entries
   // would match the first request unless the controller masks with valid.
   logic [7:0] cam_tag [4] = '{8'h05, 8'h05, 8'h05, 8'h05};
   always @(posedge clk) if (!cam_we_n) cam_tag[cam_addrs] <= cam_din;
   always_comb begin
      cam_mbits = '0;
      for (int i = 0; i < 4; i++) cam_mbits[i] = (cam_tag[i] == cam_argin);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [13:0] init_word(input int a);
      init_word = 14'((a * 113 + 7) & 16'h3FFF);
   endfunction

   // Per-transaction observations, cleared by the stimulus before each request
   int          n_req, n_tagwr, n_memwr;
   logic [1:0]  tag_addr;
   logic [7:0]  tag_din;
   logic [9:0]  wr_addr;
   logic [13:0] wr_data;
   logic [9:0]  ack_addrs [$];
   int          wait_cfg = 0;

   // Scoreboard: expectations pushed by stimulus, popped on cpu_done
   string       q_name [$];
   bit          q_chk  [$];
   logic [13:0] q_data [$];
   int          q_lat  [$];
   int          done_cnt = 0;
   int          req_cyc  = 0;

   // Main memory responder: ack after wait_cfg stall cycles, checks bus stability
   logic [13:0] mem_model [1024];
   initial begin
      int   wcnt;
      bit   pend;
      logic [24:0] pend_bus;
      for (int a = 0; a < 1024; a++) mem_model[a] = init_word(a);
      mem_ack = 1'b0; mem_rdata = '0; wcnt = 0; pend = 1'b0; pend_bus = '0;
      forever begin
         @(negedge clk);
         if (!Resetn) begin
            mem_ack = 1'b0; wcnt = 0; pend = 1'b0;
         end else begin
            if (pend) begin
               check("mem_req held until ack", 32'(mem_req), 32'd1);
               check("mem bus stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(pend_bus));
            end
            if (mem_req && wcnt >= wait_cfg) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_model[mem_addr];
               wcnt = 0; pend = 1'b0;
               if (mem_we) begin
                  mem_model[mem_addr] = mem_wdata;
                  n_memwr++; wr_addr = mem_addr; wr_data = mem_wdata;
               end else begin
                  ack_addrs.push_back(mem_addr);
               end
            end else if (mem_req) begin
               mem_ack = 1'b0; wcnt++; pend = 1'b1;
               pend_bus = {mem_we, mem_addr, mem_wdata};
            end else begin
               mem_ack = 1'b0; wcnt = 0; pend = 1'b0;
            end
         end
      end
   end

   // Monitor: latency/rdata scoreboard, CAM write log, mem_req activity
   initial begin
      bit cam_prev_low = 1'b0;
      forever begin
         @(negedge clk);
         if (cpu_req && cpu_ready) req_cyc = cyc;
         if (mem_req) n_req++;
         if (!cam_we_n) begin
            n_tagwr++; tag_addr = cam_addrs; tag_din = cam_din;
            check("cam_we_n single cycle", 32'(cam_prev_low), 32'd0);
         end
         cam_prev_low = !cam_we_n;
         if (cpu_done) begin
            done_cnt++;
            if (q_name.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected cpu_done at cycle %0d", cyc);
            end else begin
               string nm; bit chk; logic [13:0] d; int lat;
               nm = q_name.pop_front(); chk = q_chk.pop_front();
               d = q_data.pop_front(); lat = q_lat.pop_front();
               check({nm, " latency"}, 32'(cyc - req_cyc), 32'(lat));
               if (chk) check({nm, " rdata"}, 32'(cpu_rdata), 32'(d));
            end
         end
      end
   end

   task automatic clear_stats();
      n_req = 0; n_tagwr = 0; n_memwr = 0; ack_addrs.delete();
   endtask

   // Issue one request and wait (bounded) for its completion pulse
   task automatic do_txn(input string nm, input logic we, input logic [9:0] addr,
                         input logic [13:0] wd, input logic [13:0] exp_rd, input int lat);
      int guard;
      int start_done;
      clear_stats();
      q_name.push_back(nm); q_chk.push_back(!we); q_data.push_back(exp_rd); q_lat.push_back(lat);
      guard = 0;
      while (!cpu_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      start_done = done_cnt;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      guard = 0;
      while (done_cnt == start_done && guard < 200) begin @(posedge clk); #1; guard++; end
      if (done_cnt == start_done) begin
         n_checks++; n_fail++;
         $display("FAIL %s timeout: no cpu_done within 200 cycles", nm);
         q_name.delete(); q_chk.delete(); q_data.delete(); q_lat.delete();
      end
   endtask

   task automatic check_fill(input string nm, input logic [9:0] base, input logic [1:0] way, input logic [7:0] tag);
      check({nm, " fill words"}, 32'(ack_addrs.size()), 32'd4);
      for (int i = 0; i < 4 && i < ack_addrs.size(); i++)
         check({nm, " fill addr"}, 32'(ack_addrs[i]), 32'(base + 10'(i)));
      check({nm, " tag writes"}, 32'(n_tagwr), 32'd1);
      check({nm, " tag entry"}, 32'(tag_addr), 32'(way));
      check({nm, " tag value"}, 32'(tag_din), 32'(tag));
   endtask

   initial begin
      int guard;
      Resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ready/done/req/we/cam_we_n",
            32'({cpu_ready, cpu_done, mem_req, mem_we, cam_we_n}), 32'b10001);
      check("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
      check("reset mem_addr/wdata", 32'({mem_addr, mem_wdata}), 32'd0);
      check("reset cam outputs", 32'({cam_addrs, cam_din, cam_argin}), 32'd0);
      Resetn = 1'b1;
      @(posedge clk); #1;

      // Cold read miss: stale CAM entries all hold tag 0x05 but are invalid
      do_txn("rd 014 miss", 1'b0, 10'h014, '0, init_word(10'h014), 7);
      check_fill("rd 014", 10'h014, 2'd0, 8'h05);
      do_txn("rd 015 hit", 1'b0, 10'h015, '0, init_word(10'h015), 2);
      check("rd 015 hit mem_req cycles", 32'(n_req), 32'd0);

      // Fill the remaining free ways in order, then evict by round-robin
      do_txn("rd 024 miss", 1'b0, 10'h024, '0, init_word(10'h024), 7);
      check_fill("rd 024", 10'h024, 2'd1, 8'h09);
      do_txn("rd 035 miss", 1'b0, 10'h035, '0, init_word(10'h035), 7);
      check_fill("rd 035", 10'h034, 2'd2, 8'h0D);
      do_txn("rd 047 miss", 1'b0, 10'h047, '0, init_word(10'h047), 7);
      check_fill("rd 047", 10'h044, 2'd3, 8'h11);
      do_txn("rd 054 evict", 1'b0, 10'h054, '0, init_word(10'h054), 7);
      check_fill("rd 054", 10'h054, 2'd0, 8'h15);
      do_txn("rd 014 re-miss", 1'b0, 10'h014, '0, init_word(10'h014), 7);
      check_fill("rd 014 again", 10'h014, 2'd1, 8'h05);

      // Write hit updates memory and the cached copy
      do_txn("wr 015 hit", 1'b1, 10'h015, 14'h3FFF, '0, 3);
      check("wr 015 mem writes", 32'(n_memwr), 32'd1);
      check("wr 015 mem word", 32'({wr_addr, wr_data}), 32'({10'h015, 14'h3FFF}));
      check("wr 015 tag writes", 32'(n_tagwr), 32'd0);
      do_txn("rd 015 after wr", 1'b0, 10'h015, '0, 14'h3FFF, 2);
      check("rd 015 after wr mem_req cycles", 32'(n_req), 32'd0);

      // Write miss: no allocation, so the following read misses
      do_txn("wr 200 miss", 1'b1, 10'h200, 14'h1234, '0, 3);
      check("wr 200 mem word", 32'({wr_addr, wr_data}), 32'({10'h200, 14'h1234}));
      check("wr 200 tag writes", 32'(n_tagwr), 32'd0);
      do_txn("rd 200 miss", 1'b0, 10'h200, '0, 14'h1234, 7);
      check_fill("rd 200", 10'h200, 2'd2, 8'h80);

      // Three wait states per word
      wait_cfg = 3;
      do_txn("rd 2A6 slow", 1'b0, 10'h2A6, '0, init_word(10'h2A6), 19);
      check_fill("rd 2A6", 10'h2A4, 2'd3, 8'hA9);

      // Reset during the second fill word
      clear_stats();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h150;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      guard = 0;
      while (ack_addrs.size() < 1 && guard < 100) begin @(posedge clk); #1; guard++; end
      check("mid-fill first word acked", 32'(ack_addrs.size()), 32'd1);
      check("mid-fill mem_req before reset", 32'(mem_req), 32'd1);
      #2 Resetn = 1'b0;
      #1;
      check("reset drops mem_req", 32'(mem_req), 32'd0);
      check("reset ready/cam_we_n", 32'({cpu_ready, cam_we_n}), 32'b11);
      @(posedge clk); #1;
      Resetn = 1'b1;
      check("reset mid-fill tag writes", 32'(n_tagwr), 32'd0);
      wait_cfg = 0;
      @(posedge clk); #1;

      // All valid bits cleared: a previously cached line misses again
      do_txn("rd 015 post-reset", 1'b0, 10'h015, '0, 14'h3FFF, 7);
      check_fill("rd 015 post-reset", 10'h014, 2'd0, 8'h05);
      do_txn("rd 150 post-reset", 1'b0, 10'h150, '0, init_word(10'h150), 7);
      check_fill("rd 150 post-reset", 10'h150, 2'd1, 8'h54);
      do_txn("rd 016 hit", 1'b0, 10'h016, '0, init_word(10'h016), 2);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard drained", 32'(q_name.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
